// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter granting one shared resource to one of 8 requesters, with grant hold and timeout.
// Latency: 1 cycle from req sampled to registered gnt/gnt_id; release regrants with no idle bubble.
// Backpressure: owner holds the grant while its req stays high, up to MAX_HOLD cycles (0 = unlimited).
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Last hold_cnt value an owner may reach before it is force-released.
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  ONE      = N'(1);

  state_t         state, state_n;
  logic [N-1:0]   gnt_n;
  logic [IDW-1:0] gnt_id_n;
  logic [CW-1:0]  hold_cnt, hold_n;
  logic [IDW-1:0] last, last_n;
  logic           timeout_n;
  logic [IDW:0]   win;
  logic           own;
  logic           at_lim;

  // Search vec from (p+1) upward with wrap; returns {found, index}.
  function automatic logic [IDW:0] arb(input logic [N-1:0] vec, input logic [IDW-1:0] p);
    logic [IDW-1:0] s;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW:0]   res;
    s   = p + IDW'(1);
    dbl = {vec, vec} >> s;
    rot = dbl[N-1:0];
    res = '0;
    // Descending scan so the lowest rotated position (highest priority) wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) res = {1'b1, s + IDW'(j)};
    end
    return res;
  endfunction

  assign gnt_valid = (state == BUSY);

  // Next-state logic: grant from idle, hold, release-and-regrant, or timeout.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    hold_n    = hold_cnt;
    last_n    = last;
    timeout_n = 1'b0;
    win       = arb(req, (state == IDLE) ? last : gnt_id);
    own       = req[gnt_id];
    at_lim    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
    case (state)
      IDLE: begin
        if (win[IDW]) begin
          state_n  = BUSY;
          gnt_n    = ONE << win[IDW-1:0];
          gnt_id_n = win[IDW-1:0];
          hold_n   = '0;
        end
      end
      BUSY: begin
        if (own && !at_lim) begin
          // Saturating count only matters when the timeout is disabled.
          if (hold_cnt != '1) hold_n = hold_cnt + CW'(1);
        end else begin
          // Owner released or ran out of hold time; a still-requesting owner means timeout.
          last_n    = gnt_id;
          timeout_n = own;
          if (win[IDW]) begin
            gnt_n    = ONE << win[IDW-1:0];
            gnt_id_n = win[IDW-1:0];
            hold_n   = '0;
          end else begin
            state_n  = IDLE;
            gnt_n    = '0;
            gnt_id_n = '0;
            hold_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset drops any grant and makes requester 0 highest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      last     <= '1;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      hold_cnt <= hold_n;
      last     <= last_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: default instance (MAX_HOLD=16) and short-hold instance (MAX_HOLD=4).
// Latency: expected outputs compared 1 ns after each rising edge against a cycle-level model.
// Backpressure: requesters modelled as holding req until they choose to release.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] id_a, id_b;
  logic       vld_a, vld_b, to_a, to_b;

  int checks = 0;
  int errors = 0;

  // Model state per instance: owner index (-1 idle), previous owner, cycles owned so far.
  int m_owner[2];
  int m_last[2];
  int m_held[2];
  bit m_to[2];
  int m_max[2] = '{16, 4};

  always #5 clk = ~clk;

  rr_arbiter_8 u_dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(vld_a), .timeout(to_a)
  );

  rr_arbiter_8 #(.MAX_HOLD(4), .CW(3)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(vld_b), .timeout(to_b)
  );

  // First set bit searching upward from p+1 with wrap; -1 if none.
  function automatic int ref_arb(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_step(input int k, input logic [7:0] r, input logic rs);
    bit still;
    m_to[k] = 1'b0;
    if (rs) begin
      m_owner[k] = -1;
      m_last[k]  = 7;
      m_held[k]  = 0;
    end else if (m_owner[k] < 0) begin
      if (r != 0) begin
        m_owner[k] = ref_arb(r, m_last[k]);
        m_held[k]  = 1;
      end
    end else begin
      still = r[m_owner[k]];
      if (still && (m_max[k] == 0 || m_held[k] < m_max[k])) begin
        m_held[k]++;
      end else begin
        m_last[k] = m_owner[k];
        if (r != 0) begin
          m_owner[k] = ref_arb(r, m_last[k]);
          m_held[k]  = 1;
          m_to[k]    = still;
        end else begin
          m_owner[k] = -1;
          m_held[k]  = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic [7:0] g, input logic [2:0] id,
                            input logic v, input logic t);
    logic [7:0] eg;
    logic [7:0] eid;
    eg  = (m_owner[k] < 0) ? 8'h00 : (8'h01 << m_owner[k]);
    eid = (m_owner[k] < 0) ? 8'h00 : 8'(m_owner[k]);
    chk($sformatf("gnt[%0d]", k), g, eg);
    chk($sformatf("gnt_id[%0d]", k), {5'b0, id}, eid);
    chk($sformatf("gnt_valid[%0d]", k), {7'b0, v}, {7'b0, (m_owner[k] >= 0)});
    chk($sformatf("timeout[%0d]", k), {7'b0, t}, {7'b0, m_to[k]});
  endtask

  // One clock: drive inputs mid-cycle, advance model, check both instances after the edge.
  task automatic cyc(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(0, r, rs);
    model_step(1, r, rs);
    @(posedge clk);
    #1;
    check_inst(0, gnt_a, id_a, vld_a, to_a);
    check_inst(1, gnt_b, id_b, vld_b, to_b);
  endtask

  initial begin
    logic [7:0] r;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_last[k] = 7; m_held[k] = 0; m_to[k] = 1'b0;
    end

    // Reset state.
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);

    // Two requesters: 0 wins first, 7 takes over with no bubble, then idle.
    cyc(8'h81, 1'b0);
    chk("first_grant", gnt_a, 8'h01);
    cyc(8'h81, 1'b0);
    cyc(8'h81, 1'b0);
    cyc(8'h80, 1'b0);
    chk("handover_no_bubble", gnt_a, 8'h80);
    cyc(8'h00, 1'b0);
    chk("release_idle", {7'b0, vld_a}, 8'h00);

    // All requesting; each owner drops its bit for one cycle: grant order 0..7,0.
    cyc(8'hFF, 1'b0);
    chk("rot_order0", {5'b0, id_a}, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      r = 8'hFF & ~(8'h01 << ((i - 1) % 8));
      cyc(r, 1'b0);
      chk($sformatf("rot_order%0d", i), {5'b0, id_a}, 8'(i % 8));
    end
    cyc(8'h00, 1'b0);

    // Two persistent requesters: short-hold instance alternates on timeout.
    for (int i = 0; i < 20; i++) cyc(8'h05, 1'b0);
    cyc(8'h00, 1'b0);

    // Lone persistent requester: regranted on every timeout, no gap.
    for (int i = 0; i < 13; i++) begin
      cyc(8'h08, 1'b0);
      chk("lone_no_gap", gnt_b, 8'h08);
    end
    cyc(8'h00, 1'b0);

    // Reset mid-grant drops the grant; afterwards requester 0 beats 4.
    cyc(8'h10, 1'b0);
    cyc(8'h10, 1'b0);
    cyc(8'h11, 1'b1);
    chk("reset_drop", gnt_a, 8'h00);
    cyc(8'h11, 1'b0);
    chk("post_reset_prio", gnt_a, 8'h01);
    cyc(8'h00, 1'b0);

    // Long idle, then a single requester.
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0);
    cyc(8'h40, 1'b0);
    chk("single_req_id", {5'b0, id_a}, 8'h06);
    cyc(8'h00, 1'b0);

    // Randomized sticky requests with occasional bursts and resets.
    r = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
      cyc(r, ($urandom_range(0, 149) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
